// File: rtl/voice_sequencer.sv
// voice_sequencer: per-sample-frame voice allocator and combiner handshake for the two-voice synth.
// Optional feature: define VOICE_SEQ_MUTE_ON_TIMEOUT_EN to emit a midscale sample when the combiner times out.
module voice_sequencer #(
  parameter int NUM_KEYS   = 13,
  parameter int SAMPLE_DIV = 8,
  parameter int TIMEOUT    = 3,
  localparam int NW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [NUM_KEYS-1:0] keys,
  input  logic                comb_ready,
  input  logic [7:0]          comb_waveform,
  output logic                start1,
  output logic                start2,
  output logic [NW-1:0]       note1,
  output logic [NW-1:0]       note2,
  output logic                multi,
  output logic [7:0]          sample,
  output logic                sample_valid,
  output logic                timeout_err
);

  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MIDSCALE = 8'h80;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          start1_q, start1_d;
  logic          start2_q, start2_d;
  logic [NW-1:0] note1_q, note1_d;
  logic [NW-1:0] note2_q, note2_d;
  logic          multi_q, multi_d;
  logic [7:0]    sample_q, sample_d;
  logic          valid_q, valid_d;
  logic          terr_q, terr_d;

  logic          tick;
  logic          any_key;
  logic [NW-1:0] lo_idx, hi_idx;

  assign tick    = (cnt_q == CW'(SAMPLE_DIV - 1));
  assign any_key = |keys;
  assign cnt_d   = tick ? '0 : cnt_q + 1'b1;

  // Lowest set key wins the descending scan, highest set key wins the ascending one.
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (keys[i]) lo_idx = NW'(i);
    end
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) hi_idx = NW'(i);
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d  = state_q;
    wait_d   = wait_q;
    start1_d = 1'b0;
    start2_d = 1'b0;
    note1_d  = note1_q;
    note2_d  = note2_q;
    multi_d  = multi_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    terr_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          if (any_key) begin
            note1_d  = lo_idx;
            note2_d  = hi_idx;
            multi_d  = (lo_idx != hi_idx);
            start1_d = 1'b1;
            start2_d = (lo_idx != hi_idx);
            state_d  = S_START;
          end else begin
            sample_d = MIDSCALE;
            valid_d  = 1'b1;
            multi_d  = 1'b0;
          end
        end
      end
      S_START: begin
        wait_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A ready arriving on the last allowed cycle still beats the timeout.
        if (comb_ready) begin
          sample_d = comb_waveform;
          valid_d  = 1'b1;
          state_d  = S_OUT;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WW'(TIMEOUT - 1)) begin
            terr_d  = 1'b1;
            state_d = S_IDLE;
`ifdef VOICE_SEQ_MUTE_ON_TIMEOUT_EN
            sample_d = MIDSCALE;
            valid_d  = 1'b1;
`endif
          end
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wait_q   <= '0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
      note1_q  <= '0;
      note2_q  <= '0;
      multi_q  <= 1'b0;
      sample_q <= MIDSCALE;
      valid_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      start1_q <= start1_d;
      start2_q <= start2_d;
      note1_q  <= note1_d;
      note2_q  <= note2_d;
      multi_q  <= multi_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      terr_q   <= terr_d;
    end
  end

  assign start1       = start1_q;
  assign start2       = start2_q;
  assign note1        = note1_q;
  assign note2        = note2_q;
  assign multi        = multi_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_voice_sequencer.sv
// tb_voice_sequencer: randomized frame-level stimulus against a per-frame behavioural model of voice_sequencer.
// Honours VOICE_SEQ_MUTE_ON_TIMEOUT_EN the same way the design build does.
module tb_voice_sequencer;

  localparam int NUM_KEYS = 13;
  localparam int SD       = 8;
  localparam int TO       = 3;
  localparam int NW       = 4;

  typedef struct packed {
    logic          start1;
    logic          start2;
    logic [NW-1:0] note1;
    logic [NW-1:0] note2;
    logic          multi;
    logic [7:0]    sample;
    logic          sample_valid;
    logic          timeout_err;
  } outs_t;

  logic                clk = 1'b0;
  logic                n_rst = 1'b0;
  logic [NUM_KEYS-1:0] keys = '0;
  logic                comb_ready = 1'b0;
  logic [7:0]          comb_waveform = '0;
  logic                start1, start2, multi, sample_valid, timeout_err;
  logic [NW-1:0]       note1, note2;
  logic [7:0]          sample;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int ph       = 0;   // cycles since reset release

  // Model state carried between frames
  logic [NW-1:0] m_note1  = '0;
  logic [NW-1:0] m_note2  = '0;
  logic [7:0]    m_sample = 8'h80;

  voice_sequencer #(.NUM_KEYS(NUM_KEYS), .SAMPLE_DIV(SD), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .keys(keys), .comb_ready(comb_ready), .comb_waveform(comb_waveform),
    .start1(start1), .start2(start2), .note1(note1), .note2(note2), .multi(multi),
    .sample(sample), .sample_valid(sample_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic outs_t dut_outs();
    outs_t o;
    o.start1 = start1; o.start2 = start2; o.note1 = note1; o.note2 = note2; o.multi = multi;
    o.sample = sample; o.sample_valid = sample_valid; o.timeout_err = timeout_err;
    return o;
  endfunction

  function automatic string show(outs_t o);
    return $sformatf("s1=%0b s2=%0b n1=%0d n2=%0d multi=%0b sample=%h valid=%0b terr=%0b",
                     o.start1, o.start2, o.note1, o.note2, o.multi, o.sample, o.sample_valid, o.timeout_err);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    ph++;
  endtask

  // Leaves the bench in the cycle whose closing edge is the frame tick.
  task automatic wait_tick();
    while ((ph % SD) != SD - 1) cyc();
  endtask

  // One frame: keys k presented on the tick, comb_ready pulsed at tick+rdy_at (-1 = never).
  task automatic run_frame(input logic [NUM_KEYS-1:0] k, input int rdy_at, input logic [7:0] wf,
                           input bit scramble, input string tag);
    bit            any_k;
    int            lo, hi, pc, valid_s, to_s, wait_last;
    logic [7:0]    new_sample;
    outs_t         exp_o, obs;
    bit            in_wait;

    wait_tick();
    keys = k;
    comb_ready = 1'b0;

    any_k = (k != '0);
    lo = 0; hi = 0; pc = 0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (k[i]) begin
        if (pc == 0) lo = i;
        hi = i;
        pc++;
      end
    end

    valid_s = -1; to_s = -1; new_sample = m_sample; wait_last = 0;
    if (!any_k) begin
      valid_s = 1;
      new_sample = 8'h80;
    end else if (rdy_at >= 2 && rdy_at <= 1 + TO) begin
      valid_s = rdy_at + 1;
      new_sample = wf;
      wait_last = rdy_at;
    end else begin
      to_s = 2 + TO;
      wait_last = 1 + TO;
`ifdef VOICE_SEQ_MUTE_ON_TIMEOUT_EN
      valid_s = to_s;
      new_sample = 8'h80;
`endif
    end

    for (int s = 1; s < SD; s++) begin
      cyc();
      exp_o.start1       = any_k && (s == 1);
      exp_o.start2       = any_k && (pc >= 2) && (s == 1);
      exp_o.note1        = any_k ? NW'(lo) : m_note1;
      exp_o.note2        = any_k ? NW'(hi) : m_note2;
      exp_o.multi        = any_k && (pc >= 2);
      exp_o.sample       = (valid_s > 0 && s >= valid_s) ? new_sample : m_sample;
      exp_o.sample_valid = (s == valid_s);
      exp_o.timeout_err  = (s == to_s);
      obs = dut_outs();
      chk_cnt++;
      if (obs !== exp_o)
        $display("FAIL %s cycle tick+%0d: got {%s} expected {%s}", tag, s, show(obs), show(exp_o));
      else
        pass_cnt++;

      // Drive inputs for this cycle; keys and ready noise outside WAIT must be ignored.
      if (scramble) keys = NUM_KEYS'($urandom);
      in_wait = any_k && (s >= 2) && (s <= wait_last);
      if (s == rdy_at) begin
        comb_ready = 1'b1;
        comb_waveform = wf;
      end else begin
        comb_ready = in_wait ? 1'b0 : 1'($urandom);
        comb_waveform = 8'($urandom);
      end
    end

    comb_ready = 1'b0;
    if (any_k) begin
      m_note1 = NW'(lo);
      m_note2 = NW'(hi);
    end
    if (valid_s > 0) m_sample = new_sample;
  endtask

  task automatic test_reset();
    outs_t exp_o, obs;
    wait_tick();
    keys = 13'h0010;
    cyc(); cyc(); cyc();   // now in WAIT
    n_rst = 1'b0;
    #2;
    exp_o = '0;
    exp_o.sample = 8'h80;
    obs = dut_outs();
    chk_cnt++;
    if (obs !== exp_o) $display("FAIL reset_mid_wait: got {%s} expected {%s}", show(obs), show(exp_o));
    else pass_cnt++;

    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    ph = 0;
    m_note1 = '0; m_note2 = '0; m_sample = 8'h80;

    for (int c = 1; c <= SD; c++) begin
      cyc();
      exp_o = '0;
      exp_o.sample = 8'h80;
      if (c == SD) begin
        exp_o.start1 = 1'b1;
        exp_o.note1 = 4'd4;
        exp_o.note2 = 4'd4;
      end
      obs = dut_outs();
      chk_cnt++;
      if (obs !== exp_o) $display("FAIL reset_release c=%0d: got {%s} expected {%s}", c, show(obs), show(exp_o));
      else pass_cnt++;
    end
    keys = '0;
    m_note1 = 4'd4;
    m_note2 = 4'd4;   // frame started above times out; sample stays midscale either way
  endtask

  task automatic test_single_key();
    run_frame(13'h0010, 3, 8'h3C, 1'b0, "single_key");
  endtask

  task automatic test_two_keys();
    run_frame(13'h1002, int'($urandom_range(2, 1 + TO)), 8'h90, 1'b0, "two_keys");
  endtask

  task automatic test_three_keys();
    run_frame(13'h0111, int'($urandom_range(2, 1 + TO)), 8'($urandom), 1'b1, "three_keys_scramble");
  endtask

  task automatic test_timeout();
    run_frame(13'h0040, -1, 8'h00, 1'b0, "timeout_single");
    run_frame(13'h0801, 1 + TO + 1, 8'h11, 1'b1, "timeout_late_ready");
    run_frame(13'h0003, 1 + TO, 8'h5A, 1'b0, "ready_last_wait_cycle");
  endtask

  task automatic test_no_keys();
    run_frame(13'h0000, -1, 8'h00, 1'b0, "no_keys");
    run_frame(13'h0000, 2, 8'h77, 1'b1, "no_keys_ready_noise");
  endtask

  task automatic test_back_to_back();
    logic [NUM_KEYS-1:0] k;
    int mode, r;
    for (int n = 0; n < 30; n++) begin
      mode = int'($urandom_range(0, 3));
      if (mode == 0) k = '0;
      else if (mode == 1) k = NUM_KEYS'(1) << $urandom_range(0, NUM_KEYS - 1);
      else begin
        k = NUM_KEYS'($urandom);
        if (k == '0) k = 13'h1000;
      end
      r = int'($urandom_range(0, 6));
      if (r == 6) r = -1;
      run_frame(k, r, 8'($urandom), 1'b1, $sformatf("random_%0d", n));
    end
  endtask

  initial begin
    #12;
    @(negedge clk);
    n_rst = 1'b1;
    ph = 0;
    test_reset();
    test_single_key();
    test_two_keys();
    test_three_keys();
    test_timeout();
    test_no_keys();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
